// File: rtl/elastic_pkg.sv
// rtl/elastic_pkg.sv - shared widths, pointer wrap helper and operation encoding for the elastic queue
//
// Purpose : common definitions imported by elastic_dff_queue and its storage words.
//   ptr_w(depth)  : pointer width, at least 1 bit even for tiny depths
//   cnt_w(depth)  : occupancy width able to hold 0..depth inclusive
//   ptr_next()    : pointer increment that wraps depth-1 -> 0 by comparison,
//                   so depths that are not a power of two work unchanged
//   q_op_e        : per-cycle queue operation, encoded as {push, pop}
package elastic_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/en_dff_word.sv
// rtl/en_dff_word.sv - one WIDTH-bit storage word with write enable
//
// Purpose : a single queue entry; holds its value unless en_i is raised.
// Ports   :
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous, active-low; clears the word to 0
//   en_i   in  1      load d_i on the next rising edge
//   d_i    in  WIDTH  write data
//   q_o    out WIDTH  stored word
module en_dff_word #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
    end else if (en_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/elastic_dff_queue.sv
// rtl/elastic_dff_queue.sv - elastic register queue with valid/ready handshake, occupancy and flush
//
// Purpose : DEPTH words of WIDTH bits built from enable-DFF words. Decouples two
//           pipeline stages; in_ready depends on occupancy only, so there is no
//           combinational path from out_ready back to the producer.
// Config  : ELASTIC_BYPASS_EN - when defined, an empty queue forwards in_data to
//           out_data combinationally; if the consumer takes it in the same cycle
//           nothing is stored. Undefined: strict one-cycle minimum latency.
// Ports   :
//   clk        in  1                rising-edge clock
//   reset      in  1                asynchronous, active-low
//   flush      in  1                synchronous squash of all entries
//   in_valid   in  1                producer offers in_data
//   in_ready   out 1                queue can accept this cycle
//   in_data    in  WIDTH            write data
//   out_valid  out 1                out_data holds the oldest entry
//   out_ready  in  1                consumer takes out_data this cycle
//   out_data   out WIDTH            oldest entry
//   count      out clog2(DEPTH+1)   current occupancy 0..DEPTH
module elastic_dff_queue
  import elastic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic             pass_through;
  logic             push;
  logic             pop;
  q_op_e            op;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = ~full;
  assign count    = count_q;

`ifdef ELASTIC_BYPASS_EN
  logic bypass;

  // Forward the offered word while the queue is empty; a flush cycle never forwards.
  assign bypass       = empty & in_valid & ~flush;
  assign out_valid    = ~empty | bypass;
  assign out_data     = bypass ? in_data : rd_data;
  // Word consumed in the same cycle it was offered: it never touches storage.
  assign pass_through = bypass & out_ready;
`else
  assign out_valid    = ~empty;
  assign out_data     = rd_data;
  assign pass_through = 1'b0;
`endif

  // A flush cycle discards both sides of the handshake, including the storage write.
  // Pop only ever removes a stored word, never a forwarded one.
  assign push = in_valid & in_ready & ~pass_through & ~flush;
  assign pop  = out_ready & ~empty & ~flush;
  assign op   = q_op_e'({push, pop});

  // Only the word addressed by wr_ptr is enabled; every other word holds.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en[i] = push & (wr_ptr_q == PW'(i));
    end
  end

  // Compare-based read mux so unused pointer codes (non power-of-two DEPTH) select nothing.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == PW'(i)) begin
        rd_data = word_q[i];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), DEPTH));
      end
      case (op)
        OP_PUSH: count_d = count_q + CW'(1);
        OP_POP:  count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    en_dff_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .en_i  (wr_en[g]),
      .d_i   (in_data),
      .q_o   (word_q[g])
    );
  end

endmodule
